// File: rtl/sound_frame_sequencer.sv
// Game Boy APU frame sequencer: 512 Hz step divider, length/sweep/envelope tick pulses, length counters and NR52 channel-on flags.
// Define SOUND_EXT_DIV_EN to clock the sequencer from falling edges of an external DIV bit instead of the internal divider.
module sound_frame_sequencer #(
  parameter int DIV_COUNT = 8192,
  parameter int DIV_W     = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       master_en,
`ifdef SOUND_EXT_DIV_EN
  input  logic       div_bit,
`endif
  input  logic [3:0] trigger,
  input  logic [3:0] length_en,
  input  logic [3:0] length_load,
  input  logic [5:0] len_data_ch1,
  input  logic [5:0] len_data_ch2,
  input  logic [7:0] len_data_ch3,
  input  logic [5:0] len_data_ch4,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic [2:0] step,
  output logic [3:0] ch_on
);

  logic en_q;      // master_en seen on the previous edge; low on the first enabled cycle
  logic advance;   // sequencer step boundary this cycle

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= master_en;
  end

`ifdef SOUND_EXT_DIV_EN
  logic div_prev;
  logic fall_det;

  // div_prev keeps tracking while disabled, so re-enabling never sees a stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_prev <= 1'b0;
      fall_det <= 1'b0;
    end else begin
      div_prev <= div_bit;
      fall_det <= master_en & en_q & div_prev & ~div_bit;
    end
  end

  assign advance = master_en & fall_det;
`else
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  logic [DIV_W-1:0] divider;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       divider <= '0;
    else if (!master_en || !en_q)    divider <= '0;
    else if (divider == DIV_LAST)    divider <= '0;
    else                             divider <= divider + DIV_W'(1);
  end

  assign advance = master_en & en_q & (divider == DIV_LAST);
`endif

  // Ticks decode the step value before it increments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step        <= 3'd0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else if (!master_en) begin
      step        <= 3'd0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else begin
      length_tick <= advance & ~step[0];
      sweep_tick  <= advance & step[1] & ~step[0];
      env_tick    <= advance & (step == 3'd7);
      if (advance) step <= step + 3'd1;
    end
  end

  // ch3 has a 9-bit counter (256 max); the others are 7 bits (64 max).
  for (genvar i = 0; i < 4; i++) begin : g_len
    localparam int W = (i == 2) ? 9 : 7;
    localparam logic [W-1:0] FULL = W'((i == 2) ? 256 : 64);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;
    logic [W-1:0] data;
    logic         on;
    logic         on_next;

    assign data = (i == 0) ? W'(len_data_ch1) :
                  (i == 1) ? W'(len_data_ch2) :
                  (i == 2) ? W'(len_data_ch3) :
                             W'(len_data_ch4);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
      cnt_next = cnt;
      on_next  = on;
      if (trigger[i]) begin
        cnt_next = length_load[i] ? FULL - data : cnt;
        if (cnt_next == '0) cnt_next = FULL;
        on_next = 1'b1;
      end else if (length_load[i]) begin
        cnt_next = FULL - data;
      end else if (length_tick && length_en[i] && (cnt != '0)) begin
        cnt_next = cnt - W'(1);
        if (cnt_next == '0) on_next = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        on  <= 1'b0;
      end else if (!master_en) begin
        cnt <= '0;
        on  <= 1'b0;
      end else begin
        cnt <= cnt_next;
        on  <= on_next;
      end
    end

    assign ch_on[i] = on;
  end

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Bench for sound_frame_sequencer (DIV_COUNT = 16): spec-level model compared every cycle, plus directed literal checks.
module tb_sound_frame_sequencer;

  localparam int DIV_COUNT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       master_en;
  logic [3:0] trigger;
  logic [3:0] length_en;
  logic [3:0] length_load;
  logic [5:0] len_data_ch1;
  logic [5:0] len_data_ch2;
  logic [7:0] len_data_ch3;
  logic [5:0] len_data_ch4;
  logic       length_tick;
  logic       sweep_tick;
  logic       env_tick;
  logic [2:0] step;
  logic [3:0] ch_on;
`ifdef SOUND_EXT_DIV_EN
  logic       div_bit;
`endif

  int total = 0;
  int bad   = 0;
  int lt_c, st_c, et_c;

  sound_frame_sequencer #(.DIV_COUNT(DIV_COUNT), .DIV_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .master_en    (master_en),
`ifdef SOUND_EXT_DIV_EN
    .div_bit      (div_bit),
`endif
    .trigger      (trigger),
    .length_en    (length_en),
    .length_load  (length_load),
    .len_data_ch1 (len_data_ch1),
    .len_data_ch2 (len_data_ch2),
    .len_data_ch3 (len_data_ch3),
    .len_data_ch4 (len_data_ch4),
    .length_tick  (length_tick),
    .sweep_tick   (sweep_tick),
    .env_tick     (env_tick),
    .step         (step),
    .ch_on        (ch_on)
  );

  initial forever #5 clk = ~clk;

`ifdef SOUND_EXT_DIV_EN
  // Square wave of period 10 clocks, changing just after a rising edge.
  initial begin
    int cyc;
    cyc = 0;
    div_bit = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      div_bit = ((cyc / 5) % 2) == 0;
    end
  end
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_step = 0;
  bit       m_lt = 0, m_st = 0, m_et = 0;
  int       m_cnt [4] = '{0, 0, 0, 0};
  bit [3:0] m_on = 4'b0000;
`ifdef SOUND_EXT_DIV_EN
  bit       m_d1 = 0, m_d2 = 0, m_me1 = 0, m_me2 = 0;
`else
  int       m_run = 0;   // consecutive enabled edges
`endif

  function automatic int ch_data(input int ch);
    case (ch)
      0:       return int'(len_data_ch1);
      1:       return int'(len_data_ch2);
      2:       return int'(len_data_ch3);
      default: return int'(len_data_ch4);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int adv, ncnt, full;
    bit non;
    if (reset) begin
      m_step <= 0;
      m_lt <= 0; m_st <= 0; m_et <= 0;
      m_on <= 4'b0000;
      for (int c = 0; c < 4; c++) m_cnt[c] <= 0;
`ifdef SOUND_EXT_DIV_EN
      m_d1 <= 0; m_d2 <= 0; m_me1 <= 0; m_me2 <= 0;
`else
      m_run <= 0;
`endif
    end else begin
`ifdef SOUND_EXT_DIV_EN
      m_d1 <= div_bit; m_d2 <= m_d1; m_me1 <= master_en; m_me2 <= m_me1;
`endif
      if (!master_en) begin
        m_step <= 0;
        m_lt <= 0; m_st <= 0; m_et <= 0;
        m_on <= 4'b0000;
        for (int c = 0; c < 4; c++) m_cnt[c] <= 0;
`ifndef SOUND_EXT_DIV_EN
        m_run <= 0;
`endif
      end else begin
`ifdef SOUND_EXT_DIV_EN
        // A falling div_bit is seen one edge late and acted on one edge after that.
        adv = (m_me1 && m_me2 && m_d2 && !m_d1) ? 1 : 0;
`else
        // Edge number n (1-based) since enable advances when n-1 is a multiple of DIV_COUNT.
        adv = (m_run >= 1 && (m_run % DIV_COUNT) == 0) ? 1 : 0;
        m_run <= m_run + 1;
`endif
        m_lt <= (adv == 1) && (m_step % 2 == 0);
        m_st <= (adv == 1) && (m_step == 2 || m_step == 6);
        m_et <= (adv == 1) && (m_step == 7);
        m_step <= (m_step + adv) % 8;
        for (int c = 0; c < 4; c++) begin
          full = (c == 2) ? 256 : 64;
          ncnt = m_cnt[c];
          non  = m_on[c];
          if (trigger[c]) begin
            if (length_load[c]) ncnt = full - ch_data(c);
            if (ncnt == 0) ncnt = full;
            non = 1;
          end else if (length_load[c]) begin
            ncnt = full - ch_data(c);
          end else if (m_lt && length_en[c] && ncnt > 0) begin
            ncnt = ncnt - 1;
            if (ncnt == 0) non = 0;
          end
          m_cnt[c] <= ncnt;
          m_on[c]  <= non;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("length_tick", length_tick, m_lt);
    check("sweep_tick", sweep_tick, m_st);
    check("env_tick", env_tick, m_et);
    check("step", step, m_step);
    check("ch_on", ch_on, m_on);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  // ---------------- directed helpers ----------------
  task automatic tally();
    if (length_tick) lt_c++;
    if (sweep_tick)  st_c++;
    if (env_tick)    et_c++;
  endtask

  // Counts length ticks from the current cycle until ch_on[ch] drops.
  task automatic ticks_until_off(input int ch, input int budget, output int n);
    int cyc;
    n = 0;
    cyc = 0;
    while (ch_on[ch] && cyc < budget) begin
      if (length_tick) n++;
      @(negedge clk);
      cyc++;
    end
    if (ch_on[ch]) n = -1;
  endtask

`ifndef SOUND_EXT_DIV_EN
  // Raise master_en and count cycles until the first length_tick is visible.
  task automatic first_tick_latency(output int n);
    master_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!length_tick && n < 100);
  endtask
`endif

  initial begin
    int n;
    reset = 1'b1;
    master_en = 1'b0;
    trigger = '0; length_en = '0; length_load = '0;
    len_data_ch1 = '0; len_data_ch2 = '0; len_data_ch3 = '0; len_data_ch4 = '0;
    repeat (3) @(negedge clk);
    check("reset_step", step, 0);
    check("reset_ch_on", ch_on, 0);
    check("reset_ticks", {length_tick, sweep_tick, env_tick}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    lt_c = 0; st_c = 0; et_c = 0;
`ifdef SOUND_EXT_DIV_EN
    master_en = 1'b1;
    begin
      logic prevd, cur;
      bit   found;
      logic [2:0] old;
      int   m;
      prevd = div_bit;
      for (int k = 0; k < 16; k++) begin
        n = 0;
        found = 0;
        do begin
          @(negedge clk);
          n++;
          tally();
          cur = div_bit;
          found = prevd && !cur;
          prevd = cur;
        end while (!found && n < 30);
        check("ext_fall_seen", found, 1);
        old = step;
        m = 0;
        do begin
          @(negedge clk);
          m++;
          tally();
        end while (step == old && m < 10);
        check("ext_edge_latency", m, 2);
        prevd = div_bit;
      end
    end
    check("ext_length_pulses", lt_c, 8);
    check("ext_sweep_pulses", st_c, 4);
    check("ext_env_pulses", et_c, 2);
`else
    first_tick_latency(n);
    check("first_tick_latency", n, 17);
    tally();
    repeat (127) begin
      @(negedge clk);
      tally();
      if (env_tick) check("step_wrap", step, 0);
    end
    check("length_pulses", lt_c, 4);
    check("sweep_pulses", st_c, 2);
    check("env_pulses", et_c, 1);
`endif

    // ch1: load 62 -> counter 2, trigger, expires on the second length tick.
    len_data_ch1 = 6'd62; length_load = 4'b0001; length_en = 4'b0001;
    @(negedge clk);
    length_load = '0; trigger = 4'b0001;
    @(negedge clk);
    trigger = '0;
    check("ch1_on_after_trigger", ch_on[0], 1);
    ticks_until_off(0, 400, n);
    check("ch1_ticks_to_expire", n, 2);

    // ch2 collision: counter 1, trigger lands in a length_tick cycle.
    len_data_ch2 = 6'd63; length_load = 4'b0010; trigger = 4'b0010; length_en = 4'b0000;
    @(negedge clk);
    length_load = '0; trigger = '0;
    n = 0;
    while (!length_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ch2_tick_found", length_tick, 1);
    trigger = 4'b0010; length_en = 4'b0010;
    @(negedge clk);
    trigger = '0;
    check("ch2_on_after_collision", ch_on[1], 1);
    ticks_until_off(1, 400, n);
    check("ch2_ticks_to_expire", n, 1);
    length_en = '0;

    // ch3: trigger with counter 0 reloads 256.
    length_en = 4'b0100; trigger = 4'b0100;
    @(negedge clk);
    trigger = '0;
    check("ch3_on_after_trigger", ch_on[2], 1);
    ticks_until_off(2, 9500, n);
    check("ch3_ticks_to_expire", n, 256);
    length_en = '0;

    // master_en dropped mid step 5 with all channels on.
    trigger = 4'b1111;
    @(negedge clk);
    trigger = '0;
    check("all_on", ch_on, 4'b1111);
    n = 0;
    while (step != 3'd5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_step5", step, 5);
    repeat (3) @(negedge clk);
    master_en = 1'b0;
    @(negedge clk);
    check("disable_ch_on", ch_on, 0);
    check("disable_step", step, 0);
    check("disable_ticks", {length_tick, sweep_tick, env_tick}, 0);
`ifdef SOUND_EXT_DIV_EN
    master_en = 1'b1;
`else
    first_tick_latency(n);
    check("reenable_tick_latency", n, 17);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    begin
      int off_cnt;
      off_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        trigger = '0;
        length_load = '0;
        if (off_cnt == 0 && $urandom_range(0, 255) == 0) off_cnt = $urandom_range(1, 4);
        master_en = (off_cnt == 0);
        if (off_cnt > 0) off_cnt--;
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 15) == 0) trigger[c] = 1'b1;
          if ($urandom_range(0, 15) == 0) length_load[c] = 1'b1;
        end
        if (i % 64 == 0) length_en = 4'($urandom);
        len_data_ch1 = 6'($urandom_range(54, 63));
        len_data_ch2 = 6'($urandom_range(54, 63));
        len_data_ch3 = 8'($urandom_range(240, 255));
        len_data_ch4 = 6'($urandom_range(54, 63));
      end
    end
    @(negedge clk);
    trigger = 4'b1111; length_load = '0; length_en = '0; master_en = 1'b1;
    @(negedge clk);
    trigger = '0;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ch_on", ch_on, 0);
    check("async_reset_step", step, 0);
    check("async_reset_ticks", {length_tick, sweep_tick, env_tick}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
